// File: rtl/cap_readback_demux.sv
// cap_readback_demux: re-orders a capacitor frame into per-channel words via a map table.
// Optional CAP_STUCK_DETECT_EN adds all-0/all-1 word flags and a stuck-word counter.
module cap_readback_demux #(
  parameter int N_CAP = 128,
  parameter int N_CH  = 70,
  parameter int W     = 196,
  parameter int CAPW  = 7,
  parameter int CHW   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CAP*W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               map_we,
  input  logic [CHW-1:0]     map_addr,
  input  logic [CAPW-1:0]    map_cap,
  input  logic               map_en,
  output logic [W-1:0]       ch_data,
  output logic [CHW-1:0]     ch_idx,
  output logic               ch_valid,
  input  logic               ch_ready,
  output logic               ch_last,
  output logic               busy,
  output logic [15:0]        frame_cnt
`ifdef CAP_STUCK_DETECT_EN
  ,
  output logic               ch_all0,
  output logic               ch_all1,
  output logic [15:0]        stuck_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;

  state_t            state;
  logic [CHW-1:0]    ptr;
  logic [W-1:0]      frame_q [N_CAP];
  logic [CAPW-1:0]   map_cap_q [N_CH];
  logic [N_CH-1:0]   map_en_q;
  logic              accept;
  logic              map_ok;
  logic              more;
  logic [W-1:0]      sel;

  assign frame_ready = !rst && (state == IDLE);
  assign accept      = frame_valid && frame_ready;
  assign busy        = (state != IDLE);
  assign sel         = frame_q[map_cap_q[ptr]];

  assign map_ok = map_we && (state == IDLE)
               && (32'(map_addr) < N_CH)
               && (32'(map_cap) < N_CAP);

  // The map is frozen while busy, so this only depends on ptr.
  always_comb begin
    more = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (map_en_q[j] && (CHW'(j) > ptr)) more = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        map_cap_q[i] <= CAPW'(i);
        map_en_q[i]  <= 1'b1;
      end
    end else if (map_ok) begin
      map_cap_q[map_addr] <= map_cap;
      map_en_q[map_addr]  <= map_en;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < N_CAP; c++) begin
        frame_q[c] <= frame_in[c*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      ch_valid  <= 1'b0;
      ch_last   <= 1'b0;
      ch_data   <= '0;
      ch_idx    <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ptr   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (map_en_q[ptr]) begin
            ch_data  <= sel;
            ch_idx   <= ptr;
            ch_valid <= 1'b1;
            ch_last  <= !more;
            state    <= OUT;
          end else if (ptr == CHW'(N_CH - 1)) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        OUT: begin
          if (ch_valid && ch_ready) begin
            ch_valid <= 1'b0;
            if (ch_last) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAP_STUCK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_all0   <= 1'b0;
      ch_all1   <= 1'b0;
      stuck_cnt <= '0;
    end else begin
      if (state == SCAN && map_en_q[ptr]) begin
        ch_all0 <= (sel == '0);
        ch_all1 <= (&sel);
      end
      if (ch_valid && ch_ready && (ch_all0 || ch_all1)
          && stuck_cnt != 16'hFFFF) begin
        stuck_cnt <= stuck_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cap_readback_demux.sv
// Randomized bench for cap_readback_demux against a map/frame reference model.
// Honors CAP_STUCK_DETECT_EN the same way as the design.
module tb_cap_readback_demux;

  localparam int N_CAP = 128;
  localparam int N_CH  = 70;
  localparam int W     = 196;
  localparam int CAPW  = 7;
  localparam int CHW   = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_CAP*W-1:0] frame_in = '0;
  logic               frame_valid = 1'b0;
  logic               frame_ready;
  logic               map_we = 1'b0;
  logic [CHW-1:0]     map_addr = '0;
  logic [CAPW-1:0]    map_cap = '0;
  logic               map_en = 1'b0;
  logic [W-1:0]       ch_data;
  logic [CHW-1:0]     ch_idx;
  logic               ch_valid;
  logic               ch_ready = 1'b0;
  logic               ch_last;
  logic               busy;
  logic [15:0]        frame_cnt;
`ifdef CAP_STUCK_DETECT_EN
  logic               ch_all0;
  logic               ch_all1;
  logic [15:0]        stuck_cnt;
`endif

  cap_readback_demux #(
    .N_CAP(N_CAP), .N_CH(N_CH), .W(W), .CAPW(CAPW), .CHW(CHW)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .map_we(map_we), .map_addr(map_addr),
    .map_cap(map_cap), .map_en(map_en),
    .ch_data(ch_data), .ch_idx(ch_idx),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_last(ch_last), .busy(busy),
    .frame_cnt(frame_cnt)
`ifdef CAP_STUCK_DETECT_EN
    ,
    .ch_all0(ch_all0), .ch_all1(ch_all1),
    .stuck_cnt(stuck_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    bit           last;
  } exp_t;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] fw [N_CAP];
  int           m_cap [N_CH];
  bit           m_en [N_CH];
  int           m_cnt;
  int           m_stuck;
  exp_t         eq [$];

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_cap[i] = i;
      m_en[i]  = 1'b1;
    end
    m_cnt   = 0;
    m_stuck = 0;
  endtask

  task automatic rand_frame();
    for (int c = 0; c < N_CAP; c++) begin
      fw[c] = W'({$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom});
    end
  endtask

  task automatic pattern_frame();
    for (int c = 0; c < N_CAP; c++) begin
      fw[c] = {W{c[0]}} ^ W'(c);
    end
  endtask

  // Writes while the block is idle; out-of-range channels are dropped.
  task automatic map_write(input int a, input int c, input bit e);
    @(negedge clk);
    map_we   = 1'b1;
    map_addr = CHW'(a);
    map_cap  = CAPW'(c);
    map_en   = e;
    if (a < N_CH) begin
      m_cap[a] = c;
      m_en[a]  = e;
    end
    @(negedge clk);
    map_we = 1'b0;
  endtask

  task automatic run_frame(input int pct, input int stall_idx,
                           input bit busy_wr, input bit acc_wr,
                           input int abort_at);
    int cyc;
    int got;
    int first;
    int stall;
    int wa;
    int wc;
    bit we;
    bit stuck;
    @(negedge clk);
    check("ready_idle", W'(frame_ready), W'(1'b1));
    for (int c = 0; c < N_CAP; c++) frame_in[c*W +: W] = fw[c];
    frame_valid = 1'b1;
    if (acc_wr) begin
      wa = $urandom_range(0, 127);
      wc = $urandom_range(0, 127);
      we = 1'($urandom_range(0, 1));
      map_we   = 1'b1;
      map_addr = CHW'(wa);
      map_cap  = CAPW'(wc);
      map_en   = we;
      if (wa < N_CH) begin
        m_cap[wa] = wc;
        m_en[wa]  = we;
      end
    end
    eq.delete();
    for (int i = 0; i < N_CH; i++) begin
      if (m_en[i]) begin
        exp_t e;
        e.idx  = i;
        e.data = fw[m_cap[i]];
        e.last = 1'b0;
        eq.push_back(e);
      end
    end
    if (eq.size() > 0) eq[eq.size()-1].last = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    map_we = 1'b0;
    for (int c = 0; c < N_CAP; c++) frame_in[c*W +: W] = ~fw[c];
    got = 0;
    cyc = 0;
    first = -1;
    stall = 0;
    while (busy && cyc < 1000) begin
      map_we   = busy_wr && (cyc == 3);
      map_addr = '0;
      map_cap  = CAPW'(5);
      map_en   = 1'b1;
      if (ch_valid) begin
        if (got == abort_at) begin
          ch_ready = 1'b0;
          return;
        end
        if (first < 0) first = cyc;
        if (got >= eq.size()) begin
          check("extra_word", W'(got), W'(eq.size()));
          ch_ready = 1'b1;
        end else begin
          check("ch_idx", W'(ch_idx), W'(eq[got].idx));
          check("ch_data", ch_data, eq[got].data);
          check("ch_last", W'(ch_last), W'(eq[got].last));
          stuck = (eq[got].data == '0) || (&eq[got].data);
`ifdef CAP_STUCK_DETECT_EN
          check("ch_all0", W'(ch_all0), W'(eq[got].data == '0));
          check("ch_all1", W'(ch_all1), W'(&eq[got].data));
`endif
          if (eq[got].idx == stall_idx && stall < 5) begin
            ch_ready = 1'b0;
            stall++;
          end else begin
            ch_ready = ($urandom_range(0, 99) < pct);
          end
          if (ch_ready) begin
            got++;
            if (stuck && m_stuck < 16'hFFFF) m_stuck++;
          end
        end
      end else begin
        ch_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    ch_ready = 1'b0;
    map_we = 1'b0;
    check("busy_timeout", W'(busy), W'(1'b0));
    check("word_count", W'(got), W'(eq.size()));
    if (eq.size() > 0 && eq[0].idx == 0) begin
      check("first_latency", W'(first), W'(1));
    end
    m_cnt++;
    check("frame_cnt", W'(frame_cnt), W'(16'(m_cnt)));
    check("valid_after", W'(ch_valid), W'(1'b0));
    check("ready_after", W'(frame_ready), W'(1'b1));
`ifdef CAP_STUCK_DETECT_EN
    check("stuck_cnt", W'(stuck_cnt), W'(16'(m_stuck)));
`endif
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_in_rst", W'(frame_ready), W'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", W'(ch_valid), W'(1'b0));
    check("rst_last", W'(ch_last), W'(1'b0));
    check("rst_data", ch_data, W'(0));
    check("rst_idx", W'(ch_idx), W'(0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_cnt", W'(frame_cnt), W'(0));
    check("rst_ready", W'(frame_ready), W'(1'b1));

    // Identity map with the parity pattern, full throughput.
    pattern_frame();
    run_frame(100, -1, 1'b0, 1'b0, -1);

    // Stuck words on cap0/cap1.
    rand_frame();
    fw[0] = '0;
    fw[1] = '1;
    run_frame(100, -1, 1'b0, 1'b0, -1);

    // Single channel 3 sourced from cap127.
    for (int i = 0; i < N_CH; i++) map_write(i, i, 1'b0);
    map_write(3, 127, 1'b1);
    rand_frame();
    run_frame(100, -1, 1'b0, 1'b0, -1);

    // Every channel disabled.
    map_write(3, 127, 1'b0);
    rand_frame();
    run_frame(100, -1, 1'b0, 1'b0, -1);

    // Identity again with a back-pressure stall on word 10.
    for (int i = 0; i < N_CH; i++) map_write(i, i, 1'b1);
    rand_frame();
    run_frame(70, 10, 1'b0, 1'b0, -1);

    // Map writes while busy must be ignored.
    rand_frame();
    run_frame(60, -1, 1'b1, 1'b0, -1);
    rand_frame();
    run_frame(100, -1, 1'b0, 1'b0, -1);

    // Reset while word 21 is being offered.
    rand_frame();
    run_frame(100, -1, 1'b0, 1'b0, 21);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", W'(ch_valid), W'(1'b0));
    check("mid_rst_busy", W'(busy), W'(1'b0));
    check("mid_rst_ready", W'(frame_ready), W'(1'b0));
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_cnt", W'(frame_cnt), W'(0));
    check("post_rst_ready", W'(frame_ready), W'(1'b1));
    rand_frame();
    run_frame(100, -1, 1'b0, 1'b0, -1);

    // Random maps (duplicates, out-of-range addresses) and random ready.
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 8; k++) begin
        map_write($urandom_range(0, 127), $urandom_range(0, 127),
                  1'($urandom_range(0, 3) != 0));
      end
      map_write(100, 5, 1'b0);
      rand_frame();
      run_frame($urandom_range(30, 100), $urandom_range(0, 69),
                1'b0, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
